// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer in front of dmem: stores queue and drain in order,
// loads bypass unless they hit a buffered word. Optional DMEM_SB_STORE_FORWARD_EN.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_memop,
  output logic        cpu_ready,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_datain,
  output logic [2:0]  dmem_op,
  output logic        dmem_we,
  input  logic [31:0] dmem_dataout,
  output logic        sb_empty,
  output logic        sb_full
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
  } sb_entry_t;

  sb_entry_t            ent_q [DEPTH];
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       cnt_q, cnt_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 conflict, fwd_ok;
  logic [PTR_W-1:0]     scan_idx;
  logic                 st_acc, ld_acc, ld_port, drain;
  sb_entry_t            head;
`ifdef DMEM_SB_STORE_FORWARD_EN
  logic [31:0]          fwd_data;
`endif

  assign sb_empty = (cnt_q == '0);
  assign sb_full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign head     = ent_q[rd_ptr_q];

  // Scan oldest to newest so the last hit is the youngest matching store.
  always_comb begin
    conflict = 1'b0;
    fwd_ok   = 1'b0;
    scan_idx = rd_ptr_q;
`ifdef DMEM_SB_STORE_FORWARD_EN
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr_q + PTR_W'(k);
      if (vld_q[scan_idx] && (ent_q[scan_idx].addr[31:2] == cpu_addr[31:2])) begin
        conflict = 1'b1;
`ifdef DMEM_SB_STORE_FORWARD_EN
        fwd_ok   = (cpu_memop == 3'b000) && (ent_q[scan_idx].op == 3'b000) &&
                   (ent_q[scan_idx].addr == cpu_addr);
        fwd_data = ent_q[scan_idx].data;
`endif
      end
    end
  end

  assign st_acc    = cpu_req &  cpu_we & ~sb_full;
  assign ld_acc    = cpu_req & ~cpu_we & ~sb_full & (~conflict | fwd_ok);
  // A forwarded load never touches dmem, leaving the port to the drain.
  assign ld_port   = ld_acc & ~fwd_ok;
  assign drain     = ~sb_empty & ~ld_port;
  assign cpu_ready = st_acc | ld_acc;

  assign dmem_we     = drain;
  assign dmem_addr   = ld_port ? cpu_addr  : (sb_empty ? 32'h0 : head.addr);
  assign dmem_op     = ld_port ? cpu_memop : (sb_empty ? 3'b000 : head.op);
  assign dmem_datain = sb_empty ? 32'h0 : head.data;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    if (st_acc) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (drain) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    case ({st_acc, drain})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    rvalid_d = ld_acc;
    rdata_d  = rdata_q;
    if (ld_acc) begin
`ifdef DMEM_SB_STORE_FORWARD_EN
      rdata_d = fwd_ok ? fwd_data : dmem_dataout;
`else
      rdata_d = dmem_dataout;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Payload needs no reset; occupancy is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (st_acc) ent_q[wr_ptr_q] <= '{addr: cpu_addr, data: cpu_wdata, op: cpu_memop};
  end

  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-write buffer between the CPU data port and the data memory `dmem`.
- Stores are accepted in one cycle into a small FIFO and drained to `dmem` one per cycle, in program order.
- Loads read `dmem` directly. A load stalls while any buffered store targets the same 32-bit word.
- `sb_empty` lets the CPU hold `done` until every store has reached memory.

Parameters:
- DEPTH, 4, number of store entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; `dmem` write edge is posedge clk.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-aligned as the CPU produces it.
- cpu_memop  in  3  000 w, 001 b, 010 h, 101 bu, 110 hu.
- cpu_ready  out  1  request accepted this cycle (combinational).
- cpu_rvalid  out  1  load data valid (registered).
- cpu_rdata  out  32  load data (registered).
- dmem_addr  out  32  to `dmem` addr.
- dmem_datain  out  32  to `dmem` datain.
- dmem_op  out  3  to `dmem` memop.
- dmem_we  out  1  to `dmem` we.
- dmem_dataout  in  32  from `dmem`; combinational read, already extended per dmem_op.
- sb_empty  out  1  buffer holds no stores.
- sb_full  out  1  buffer holds DEPTH stores.

Behaviour:
- Reset (async, immediate):
  - Write pointer, read pointer and count = 0.
  - cpu_rvalid = 0, cpu_rdata = 0.
  - Resulting outputs: sb_empty = 1, sb_full = 0, dmem_we = 0.
  - A reset mid-drain discards all pending stores; nothing partial is written after reset asserts.
- Entry contents: {addr[31:0], wdata[31:0], memop[2:0]}. Word tag = addr[31:2].
- Conflict: a load's addr[31:2] equals the tag of any valid entry. Byte lanes are ignored.
- Store acceptance: cpu_ready = cpu_req & cpu_we & !sb_full. On accept, write the entry at the write pointer; the pointer increments and wraps modulo DEPTH.
- Load acceptance: cpu_ready = cpu_req & !cpu_we & !conflict & !sb_full.
  - On accept, the `dmem` port carries the load: dmem_addr = cpu_addr, dmem_op = cpu_memop, dmem_we = 0.
  - Next edge: cpu_rdata <= dmem_dataout and cpu_rvalid <= 1, so latency is 1 cycle.
  - cpu_rvalid is a single-cycle pulse.
- Port arbitration, one `dmem` access per cycle:
  - An accepted load owns the port.
  - Otherwise, if count > 0, the head entry drives the port: dmem_addr, dmem_datain and dmem_op from the entry, dmem_we = 1. Pop at the edge; the read pointer wraps modulo DEPTH.
  - When full, loads stall, so the drain always progresses; this prevents starvation.
  - Idle: dmem_we = 0. dmem_addr and dmem_op hold the head entry's values (or 0 if empty).
- Count:
  - Simultaneous enqueue and drain leaves count unchanged.
  - Enqueue is never accepted while full, even if a drain occurs the same cycle.
- Status: sb_empty = (count == 0), sb_full = (count == DEPTH). Both are combinational from count.
- Loads with cpu_memop in {011, 100, 111} pass through as `dmem` default (word).
- Stores with memop not in {000, 001, 010} are buffered and drained unchanged; `dmem` masks them to no write.
- Store ordering to `dmem` is identical to acceptance order.

Optional Feature:
- Macro: DMEM_SB_STORE_FORWARD_EN.
- Defined: a conflicting lw (000) accepts without stall when the newest matching entry is an sw (000) with an identical full address.
  - cpu_rdata <= that entry's wdata, with 1-cycle latency.
  - The drain may use the port in the same cycle.
  - Every other conflict still stalls.
- Undefined: every conflict stalls until the matching entries drain.

Test Plan:
- Reset then idle -> sb_empty = 1, cpu_rvalid = 0, dmem_we = 0; assert reset mid-drain with 3 entries -> count 0 immediately, no further dmem_we.
- 4 back-to-back sw to 0x100/0x104/0x108/0x10C (data 0x11..0x44) -> cpu_ready = 1 on all; `dmem` writes in order; sb_empty = 1 after the last drain.
- 5 stores with no intervening idle and drains blocked by loads -> sb_full = 1, 5th store sees cpu_ready = 0 until one pop, then accepts.
- sb 0xAB to 0x201, then lbu 0x203 -> load stalls until drain, then cpu_rdata = mem byte, rvalid 1 cycle after accept; lw 0x400 (no conflict) while buffer non-empty -> accepted same cycle, drain paused.
- Wrap: 10 stores interleaved with drains -> pointers wrap; `dmem` contents match the golden model.
- With DMEM_SB_STORE_FORWARD_EN: sw 0xDEADBEEF to 0x300, immediate lw 0x300 -> no stall, cpu_rdata = 0xDEADBEEF; lh 0x300 -> stalls.
